// File: rtl/cpu_dp_if.sv
// Control/status bundle between the instruction controller and the
// execution datapath. The controller drives the decoded fields; the
// datapath returns its registered flags and the accumulator value.
interface cpu_dp_if #(
    parameter int WIDTH           = 8,
    parameter int ALU_INSTR_WIDTH = 4,
    parameter int REG_F_SEL_SIZE  = 4,
    parameter int IN_B_SEL_SIZE   = 2
);
    logic [ALU_INSTR_WIDTH-1:0] alu_in;
    logic [WIDTH-1:0]           imm;
    logic [IN_B_SEL_SIZE-1:0]   in_b_sel;
    logic [REG_F_SEL_SIZE-1:0]  reg_f_sel;
    logic                       en_reg_f;
    logic [WIDTH-1:0]           d_mem_addr;
    logic                       d_mem_addr_mode;
    logic                       en_d_mem;
    logic                       en_acc;
    logic                       z_flag;
    logic                       c_flag;
    logic [WIDTH-1:0]           acc_out;

    // Controller side: issues the decoded instruction fields, observes flags.
    modport master (
        output alu_in, imm, in_b_sel, reg_f_sel, en_reg_f,
               d_mem_addr, d_mem_addr_mode, en_d_mem, en_acc,
        input  z_flag, c_flag, acc_out
    );

    // Datapath side: executes the instruction, reports flags and ACC.
    modport slave (
        input  alu_in, imm, in_b_sel, reg_f_sel, en_reg_f,
               d_mem_addr, d_mem_addr_mode, en_d_mem, en_acc,
        output z_flag, c_flag, acc_out
    );
endinterface

// File: rtl/cpu_dp.sv
// Accumulator-based execution datapath: ALU, accumulator, register file,
// data memory and zero/carry flags. One instruction completes per clock.
// Stores always use the pre-edge ACC and address; same-cycle reads of a
// location being written return the old contents.
module cpu_dp #(
    parameter int WIDTH           = 8,
    parameter int ALU_INSTR_WIDTH = 4,
    parameter int REG_F_SEL_SIZE  = 4,
    parameter int IN_B_SEL_SIZE   = 2,
    parameter int D_MEM_DEPTH     = 256
) (
    input  logic      clk,
    input  logic      rst,
    cpu_dp_if.slave   bus
);
    localparam int REG_F_N  = 2 ** REG_F_SEL_SIZE;
    localparam int D_ADDR_W = (D_MEM_DEPTH > 1) ? $clog2(D_MEM_DEPTH) : 1;

    localparam logic [ALU_INSTR_WIDTH-1:0] OP_NOP = ALU_INSTR_WIDTH'(0);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_LD  = ALU_INSTR_WIDTH'(1);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_ADD = ALU_INSTR_WIDTH'(2);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_SUB = ALU_INSTR_WIDTH'(3);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_AND = ALU_INSTR_WIDTH'(4);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_OR  = ALU_INSTR_WIDTH'(5);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_XOR = ALU_INSTR_WIDTH'(6);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_NOT = ALU_INSTR_WIDTH'(7);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_SHL = ALU_INSTR_WIDTH'(8);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_SHR = ALU_INSTR_WIDTH'(9);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_INC = ALU_INSTR_WIDTH'(10);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_DEC = ALU_INSTR_WIDTH'(11);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_ROL = ALU_INSTR_WIDTH'(12);
    localparam logic [ALU_INSTR_WIDTH-1:0] OP_ROR = ALU_INSTR_WIDTH'(13);

    logic [WIDTH-1:0]    acc_q, acc_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic [WIDTH-1:0]    reg_f_q [REG_F_N];
    logic [WIDTH-1:0]    reg_f_d [REG_F_N];
    logic [WIDTH-1:0]    d_mem   [D_MEM_DEPTH];

    logic [WIDTH-1:0]    ea_full;
    logic [D_ADDR_W-1:0] ea_idx;
    logic [WIDTH-1:0]    op_b;
    logic [WIDTH-1:0]    alu_r;
    logic                alu_c;
    logic [WIDTH:0]      ext;

    // Effective address (direct or via old ACC) and operand-B selection.
    always_comb begin
        ea_full = bus.d_mem_addr_mode ? acc_q : bus.d_mem_addr;
        ea_idx  = D_ADDR_W'(32'(ea_full) % D_MEM_DEPTH);
        op_b    = bus.imm;
        case (bus.in_b_sel)
            IN_B_SEL_SIZE'(0): op_b = bus.imm;
            IN_B_SEL_SIZE'(1): op_b = reg_f_q[bus.reg_f_sel];
            IN_B_SEL_SIZE'(2): op_b = d_mem[ea_idx];
            IN_B_SEL_SIZE'(3): op_b = acc_q;
            default:           op_b = bus.imm;
        endcase
    end

    // ALU: result plus next carry; opcodes without a carry keep c_q.
    always_comb begin
        alu_r = acc_q;
        alu_c = c_q;
        ext   = '0;
        case (bus.alu_in)
            OP_NOP: alu_r = acc_q;
            OP_LD:  alu_r = op_b;
            OP_ADD: begin
                ext   = {1'b0, acc_q} + {1'b0, op_b};
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
            end
            OP_SUB: begin
                ext   = {1'b0, acc_q} - {1'b0, op_b};
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
            end
            OP_AND: alu_r = acc_q & op_b;
            OP_OR:  alu_r = acc_q | op_b;
            OP_XOR: alu_r = acc_q ^ op_b;
            OP_NOT: alu_r = ~acc_q;
            OP_SHL: begin
                alu_r = {acc_q[WIDTH-2:0], 1'b0};
                alu_c = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_r = {1'b0, acc_q[WIDTH-1:1]};
                alu_c = acc_q[0];
            end
            OP_INC: begin
                ext   = {1'b0, acc_q} + (WIDTH+1)'(1);
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
            end
            OP_DEC: begin
                ext   = {1'b0, acc_q} - (WIDTH+1)'(1);
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
            end
            OP_ROL: alu_r = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
            OP_ROR: alu_r = {acc_q[0], acc_q[WIDTH-1:1]};
            default: alu_r = acc_q;
        endcase
    end

    // Next state for accumulator, flags and register file.
    always_comb begin
        acc_d = bus.en_acc ? alu_r : acc_q;
        z_d   = bus.en_acc ? (alu_r == '0) : z_q;
        c_d   = bus.en_acc ? alu_c : c_q;
        for (int i = 0; i < REG_F_N; i++) begin
            reg_f_d[i] = reg_f_q[i];
            if (bus.en_reg_f && (bus.reg_f_sel == REG_F_SEL_SIZE'(i)))
                reg_f_d[i] = acc_q;
        end
    end

    // State registers; reset clears ACC, flags and every register-file entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            for (int i = 0; i < REG_F_N; i++)
                reg_f_q[i] <= '0;
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
            c_q   <= c_d;
            for (int i = 0; i < REG_F_N; i++)
                reg_f_q[i] <= reg_f_d[i];
        end
    end

    // Data-memory write port; contents survive reset but reset blocks writes.
    always_ff @(posedge clk) begin
        if (rst && bus.en_d_mem)
            d_mem[ea_idx] <= acc_q;
    end

    assign bus.acc_out = acc_q;
    assign bus.z_flag  = z_q;
    assign bus.c_flag  = c_q;
endmodule

// File: tb/tb_cpu_dp.sv
// Table-driven bench for cpu_dp: each record carries one instruction and the
// ACC/z/c expected after its clock edge. Expectations go into a scoreboard
// queue as the instruction is driven and are compared after the edge.
module tb_cpu_dp;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    cpu_dp_if #(.WIDTH(8), .ALU_INSTR_WIDTH(4), .REG_F_SEL_SIZE(4), .IN_B_SEL_SIZE(2)) bus ();

    cpu_dp #(
        .WIDTH(8), .ALU_INSTR_WIDTH(4), .REG_F_SEL_SIZE(4),
        .IN_B_SEL_SIZE(2), .D_MEM_DEPTH(256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] op;
        logic [7:0] imm;
        logic [1:0] bsel;
        logic [3:0] rsel;
        logic       en_rf;
        logic [7:0] addr;
        logic       mode;
        logic       en_dm;
        logic       en_acc;
        logic [7:0] e_acc;
        logic       e_z;
        logic       e_c;
    } vec_t;

    typedef struct packed {
        logic [7:0] acc;
        logic       z;
        logic       c;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [3:0] NOP = 4'd0, LD = 4'd1, ADD = 4'd2, SUB = 4'd3,
                           AND_ = 4'd4, OR_ = 4'd5, XOR_ = 4'd6, NOT_ = 4'd7,
                           SHL = 4'd8, SHR = 4'd9, INC = 4'd10, DEC = 4'd11,
                           ROL = 4'd12, ROR = 4'd13, R14 = 4'd14;

    // Shorthand for table entries.
    task automatic add(input logic r, input logic [3:0] op, input logic [7:0] imm,
                       input logic [1:0] bsel, input logic [3:0] rsel, input logic en_rf,
                       input logic [7:0] addr, input logic mode, input logic en_dm,
                       input logic en_acc, input logic [7:0] ea, input logic ez,
                       input logic ec);
        vec_t v;
        v.rst_n = r; v.op = op; v.imm = imm; v.bsel = bsel; v.rsel = rsel;
        v.en_rf = en_rf; v.addr = addr; v.mode = mode; v.en_dm = en_dm;
        v.en_acc = en_acc; v.e_acc = ea; v.e_z = ez; v.e_c = ec;
        tbl.push_back(v);
    endtask

    // Plain accumulator instruction with immediate/other operand, no stores.
    task automatic alu(input logic [3:0] op, input logic [7:0] imm, input logic [1:0] bsel,
                       input logic [3:0] rsel, input logic [7:0] addr, input logic mode,
                       input logic [7:0] ea, input logic ez, input logic ec);
        add(1'b1, op, imm, bsel, rsel, 1'b0, addr, mode, 1'b0, 1'b1, ea, ez, ec);
    endtask

    task automatic check(input int idx, input string what, input logic [7:0] got,
                         input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %02h required %02h", idx, what, got, want);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Reset with enables active: LD 0x55 must be ignored.
        add(1'b0, LD, 8'h55, 2'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        add(1'b0, LD, 8'h55, 2'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        // Every register-file entry reads zero.
        for (int i = 0; i < 16; i++)
            alu(LD, 8'h00, 2'd1, 4'(i), 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        // LD / ADD carry / SUB to zero.
        alu(LD,  8'hF0, 2'd0, 4'd0, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0);
        alu(ADD, 8'h20, 2'd0, 4'd0, 8'h00, 1'b0, 8'h10, 1'b0, 1'b1);
        alu(SUB, 8'h10, 2'd0, 4'd0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        // Register-file store of old ACC while ACC loads a new value.
        alu(LD,  8'h3C, 2'd0, 4'd0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0);
        add(1'b1, LD, 8'h01, 2'd0, 4'd5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        alu(ADD, 8'h00, 2'd1, 4'd5, 8'h00, 1'b0, 8'h3D, 1'b0, 1'b0);
        // Read and write reg_f[5] in one cycle: read returns old 0x3C.
        add(1'b1, LD, 8'h00, 2'd1, 4'd5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        alu(LD,  8'h00, 2'd1, 4'd5, 8'h00, 1'b0, 8'h3D, 1'b0, 1'b0);
        // Data memory: direct store, indirect load.
        alu(LD,  8'h77, 2'd0, 4'd0, 8'h00, 1'b0, 8'h77, 1'b0, 1'b0);
        add(1'b1, SUB, 8'hFF, 2'd0, 4'd0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        alu(LD,  8'h12, 2'd0, 4'd0, 8'h00, 1'b0, 8'h12, 1'b0, 1'b0);
        alu(LD,  8'h00, 2'd2, 4'd0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0);
        // Top address 0xFF.
        alu(LD,  8'hA5, 2'd0, 4'd0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
        add(1'b1, NOP, 8'h00, 2'd0, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        alu(LD,  8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        alu(LD,  8'h00, 2'd2, 4'd0, 8'hFF, 1'b0, 8'hA5, 1'b0, 1'b0);
        // Indirect store with en_acc: EA and data both from old ACC (0x40).
        alu(LD,  8'h40, 2'd0, 4'd0, 8'h00, 1'b0, 8'h40, 1'b0, 1'b0);
        add(1'b1, LD, 8'h99, 2'd0, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        alu(LD,  8'h00, 2'd2, 4'd0, 8'h40, 1'b0, 8'h40, 1'b0, 1'b0);
        // Read and write d_mem[0x12] in one cycle: read returns old 0x77.
        add(1'b1, LD, 8'h00, 2'd2, 4'd0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        alu(LD,  8'h00, 2'd2, 4'd0, 8'h12, 1'b0, 8'h40, 1'b0, 1'b0);
        // Shifts and rotates.
        alu(LD,  8'h81, 2'd0, 4'd0, 8'h00, 1'b0, 8'h81, 1'b0, 1'b0);
        alu(SHL, 8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1);
        alu(ROR, 8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1);
        alu(SHR, 8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        alu(DEC, 8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1);
        alu(INC, 8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        // Logic ops (carry held at 1), ROL, ACC+ACC, borrow.
        alu(LD,   8'h0F, 2'd0, 4'd0, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b1);
        alu(OR_,  8'hF0, 2'd0, 4'd0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1);
        alu(AND_, 8'h3C, 2'd0, 4'd0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1);
        alu(XOR_, 8'hFF, 2'd0, 4'd0, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b1);
        alu(NOT_, 8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1);
        alu(ROL,  8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'h78, 1'b0, 1'b1);
        alu(ADD,  8'h00, 2'd3, 4'd0, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0);
        alu(INC,  8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'hF1, 1'b0, 1'b0);
        alu(SUB,  8'hF2, 2'd0, 4'd0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1);
        alu(NOP,  8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1);
        alu(R14,  8'h00, 2'd0, 4'd0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1);
        // Flag hold: SUB 0xFF with en_acc=0 changes nothing.
        add(1'b1, SUB, 8'hFF, 2'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
        // Mid-operation reset must block the reg_f and d_mem writes.
        alu(LD,  8'h66, 2'd0, 4'd0, 8'h00, 1'b0, 8'h66, 1'b0, 1'b1);
        add(1'b1, NOP, 8'h00, 2'd0, 4'd0, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0, 8'h66, 1'b0, 1'b1);
        alu(LD,  8'hAA, 2'd0, 4'd0, 8'h00, 1'b0, 8'hAA, 1'b0, 1'b1);
        add(1'b0, LD, 8'h55, 2'd0, 4'd7, 1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        alu(LD,  8'h00, 2'd2, 4'd0, 8'h30, 1'b0, 8'h66, 1'b0, 1'b0);
        alu(LD,  8'h00, 2'd1, 4'd7, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        alu(LD,  8'h00, 2'd1, 4'd5, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

        // Apply each record: drive, queue its expectation, compare after the edge.
        for (int i = 0; i < tbl.size(); i++) begin
            rst                 = tbl[i].rst_n;
            bus.alu_in          = tbl[i].op;
            bus.imm             = tbl[i].imm;
            bus.in_b_sel        = tbl[i].bsel;
            bus.reg_f_sel       = tbl[i].rsel;
            bus.en_reg_f        = tbl[i].en_rf;
            bus.d_mem_addr      = tbl[i].addr;
            bus.d_mem_addr_mode = tbl[i].mode;
            bus.en_d_mem        = tbl[i].en_dm;
            bus.en_acc          = tbl[i].en_acc;
            sb.push_back('{acc: tbl[i].e_acc, z: tbl[i].e_z, c: tbl[i].e_c});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(i, "acc", bus.acc_out, e.acc);
            check(i, "z",   8'(bus.z_flag), 8'(e.z));
            check(i, "c",   8'(bus.c_flag), 8'(e.c));
            $display("vec%0d op=%0d imm=%02h bsel=%0d -> acc=%02h z=%0b c=%0b",
                     i, tbl[i].op, tbl[i].imm, tbl[i].bsel, bus.acc_out,
                     bus.z_flag, bus.c_flag);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
